// File: rtl/lut_multiplier_seq.sv
// ---------------------------------------------------------------------------
// lut_multiplier_seq
//
// Sequential LUT multiplier for unsigned operands.
// An operation has two phases:
//   FILL  builds a table of the 2^DIGIT_BITS multiples of operand 0.
//   MULT  consumes operand 1 one DIGIT_BITS-wide digit per cycle, MSB first.
//         Each cycle it shifts the accumulator and adds the selected table entry.
//
// Latency from the accepting edge to done is L = 2^DIGIT_BITS - 1 + WIDTH_B/DIGIT_BITS.
//
// Parameters
//   WIDTH_A     multiplicand width
//   WIDTH_B     multiplier width (a multiple of DIGIT_BITS)
//   DIGIT_BITS  digit width, 1..4
//
// Ports
//   clk_seq              clock, rising edge
//   resetn_seq           synchronous reset, active high
//   start_seq            request, sampled only while idle
//   source_number_seq_0  multiplicand
//   source_number_seq_1  multiplier
//   busy_seq             operation in progress (FILL or MULT)
//   done_seq             one-cycle pulse; result_seq is valid from this cycle
//   result_seq           product, held until the next done
// ---------------------------------------------------------------------------
module lut_multiplier_seq #(
    parameter int unsigned WIDTH_A    = 32,
    parameter int unsigned WIDTH_B    = 32,
    parameter int unsigned DIGIT_BITS = 2
) (
    input  logic                       clk_seq,
    input  logic                       resetn_seq,
    input  logic                       start_seq,
    input  logic [WIDTH_A-1:0]         source_number_seq_0,
    input  logic [WIDTH_B-1:0]         source_number_seq_1,
    output logic                       busy_seq,
    output logic                       done_seq,
    output logic [WIDTH_A+WIDTH_B-1:0] result_seq
);

    localparam int unsigned ACC_W     = WIDTH_A + WIDTH_B;
    localparam int unsigned LUT_W     = WIDTH_A + DIGIT_BITS;
    localparam int unsigned LUT_DEPTH = 1 << DIGIT_BITS;
    localparam int unsigned N_DIGITS  = WIDTH_B / DIGIT_BITS;
    localparam int unsigned CNT_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [DIGIT_BITS-1:0] IDX_LAST = '1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(N_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_MULT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH_A-1:0]     a_q, a_d;
    logic [WIDTH_B-1:0]     b_q, b_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [LUT_W-1:0]       lut_q [LUT_DEPTH];
    logic [LUT_W-1:0]       lut_d [LUT_DEPTH];
    logic [DIGIT_BITS-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [ACC_W-1:0]       result_q, result_d;

    logic [DIGIT_BITS-1:0]  digit;
    logic [ACC_W-1:0]       acc_next;

    // State and datapath registers; reset clears everything including the table.
    always_ff @(posedge clk_seq) begin
        if (resetn_seq) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            for (int i = 0; i < int'(LUT_DEPTH); i++) begin
                lut_q[i] <= lut_d[i];
            end
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        for (int i = 0; i < int'(LUT_DEPTH); i++) begin
            lut_d[i] = lut_q[i];
        end

        // The MSB digit of the shifting multiplier selects the table entry.
        digit    = b_q[WIDTH_B-1 -: DIGIT_BITS];
        acc_next = (acc_q << DIGIT_BITS) + ACC_W'(lut_q[digit]);

        case (state_q)
            ST_IDLE: begin
                if (start_seq) begin
                    a_d      = source_number_seq_0;
                    b_d      = source_number_seq_1;
                    acc_d    = '0;
                    lut_d[0] = '0;
                    idx_d    = DIGIT_BITS'(1);
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_FILL;
                end
            end

            ST_FILL: begin
                // Each entry is the previous multiple plus the multiplicand.
                lut_d[idx_q] = lut_q[idx_q - DIGIT_BITS'(1)] + LUT_W'(a_q);
                idx_d        = idx_q + DIGIT_BITS'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_MULT;
                end
            end

            ST_MULT: begin
                acc_d = acc_next;
                b_d   = b_q << DIGIT_BITS;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = acc_next;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_seq   = busy_q;
    assign done_seq   = done_q;
    assign result_seq = result_q;

endmodule

// File: tb/tb_lut_multiplier_seq.sv
// ---------------------------------------------------------------------------
// tb_lut_multiplier_seq
//
// Self-checking bench.
// The default 32x32 / 2-bit-digit instance covers the handshake and timing
// scenarios. Three 16x16 instances with digit widths 1, 2 and 4 are driven
// with the same random operand pairs.
// Expected products come from plain integer multiplication.
// Expected latencies come from 2^D - 1 + WIDTH_B/D.
// ---------------------------------------------------------------------------
module tb_lut_multiplier_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0;
    logic [31:0] a0, b0;
    logic        busy0, done0;
    logic [63:0] res0;

    logic        start16;
    logic [15:0] a16, b16;
    logic [2:0]  busy_s, done_s;
    logic [31:0] res_s [3];

    int n_tests = 0;
    int n_fail  = 0;

    localparam int L0 = 19;
    int exp_lat [3] = '{17, 11, 19};
    int dig     [3] = '{1, 2, 4};

    lut_multiplier_seq #(.WIDTH_A(32), .WIDTH_B(32), .DIGIT_BITS(2)) dut (
        .clk_seq(clk), .resetn_seq(rst), .start_seq(start0),
        .source_number_seq_0(a0), .source_number_seq_1(b0),
        .busy_seq(busy0), .done_seq(done0), .result_seq(res0)
    );

    lut_multiplier_seq #(.WIDTH_A(16), .WIDTH_B(16), .DIGIT_BITS(1)) dut_d1 (
        .clk_seq(clk), .resetn_seq(rst), .start_seq(start16),
        .source_number_seq_0(a16), .source_number_seq_1(b16),
        .busy_seq(busy_s[0]), .done_seq(done_s[0]), .result_seq(res_s[0])
    );

    lut_multiplier_seq #(.WIDTH_A(16), .WIDTH_B(16), .DIGIT_BITS(2)) dut_d2 (
        .clk_seq(clk), .resetn_seq(rst), .start_seq(start16),
        .source_number_seq_0(a16), .source_number_seq_1(b16),
        .busy_seq(busy_s[1]), .done_seq(done_s[1]), .result_seq(res_s[1])
    );

    lut_multiplier_seq #(.WIDTH_A(16), .WIDTH_B(16), .DIGIT_BITS(4)) dut_d4 (
        .clk_seq(clk), .resetn_seq(rst), .start_seq(start16),
        .source_number_seq_0(a16), .source_number_seq_1(b16),
        .busy_seq(busy_s[2]), .done_seq(done_s[2]), .result_seq(res_s[2])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul32(input logic [31:0] a, input logic [31:0] b);
        return {32'h0, a} * {32'h0, b};
    endfunction

    function automatic logic [63:0] ref_mul16(input logic [15:0] a, input logic [15:0] b);
        return 64'({16'h0, a} * {16'h0, b});
    endfunction

    // Present a one-cycle start; returns at the first negedge after the accepting edge.
    task automatic launch0(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        a0     = a;
        b0     = b;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    // Wait for done. lat is counted in cycles after the accepting edge.
    task automatic wait_done0(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int j = 0; j <= 40; j++) begin
            if (done0) begin
                lat = j;
                break;
            end
            if (busy0) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run0(input string tag, input logic [31:0] a, input logic [31:0] b);
        int lat, bc;
        launch0(a, b);
        wait_done0(lat, bc);
        check_val({tag, "_lat"}, 64'(lat), 64'(L0));
        check_val({tag, "_res"}, res0, ref_mul32(a, b));
        check_val({tag, "_busy_cycles"}, 64'(bc), 64'(L0));
        check_val({tag, "_busy_at_done"}, 64'(busy0), 64'd0);
        @(negedge clk);
        check_val({tag, "_done_width"}, 64'(done0), 64'd0);
    endtask

    initial begin
        int          lat, bc, k, seen;
        logic [31:0] ha [3];
        logic [31:0] hb [3];
        logic [31:0] ta, tb;
        int          lat_s [3];
        logic [15:0] sa, sb;

        rst     = 1'b1;
        start0  = 1'b1;
        a0      = 32'd5;
        b0      = 32'd6;
        start16 = 1'b0;
        a16     = '0;
        b16     = '0;

        // Reset, with a start presented during reset
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(busy0), 64'd0);
        check_val("rst_done", 64'(done0), 64'd0);
        check_val("rst_res",  res0, 64'd0);
        rst    = 1'b0;
        start0 = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_start_ignored_busy", 64'(busy0), 64'd0);
        check_val("rst_start_ignored_res",  res0, 64'd0);
        check_val("rst_sweep_res", 64'(res_s[2]), 64'd0);

        // Basic product and maximum operands
        run0("basic", 32'h0000_0007, 32'h0000_0003);
        check_val("basic_const", res0, 64'h15);
        run0("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_val("max_const", res0, 64'hFFFF_FFFE_0000_0001);
        run0("zero_a", 32'h0, 32'h1234_5678);
        run0("zero_b", 32'h9ABC_DEF0, 32'h0);

        // New operands and a start presented mid-operation are ignored
        ta = 32'hDEAD_BEEF;
        tb = 32'h0BAD_F00D;
        launch0(ta, tb);
        lat = -1;
        for (int j = 0; j <= 40; j++) begin
            if (done0) begin
                lat = j;
                break;
            end
            if (j == 5) begin
                a0     = 32'h1111_1111;
                b0     = 32'h2222_2222;
                start0 = 1'b1;
            end else begin
                start0 = 1'b0;
            end
            @(negedge clk);
        end
        start0 = 1'b0;
        check_val("midop_lat", 64'(lat), 64'(L0));
        check_val("midop_res", res0, ref_mul32(ta, tb));
        @(negedge clk);
        check_val("midop_no_requeue", 64'(busy0), 64'd0);

        // Held start: the IDLE cycle after each done accepts the next request
        for (int i = 0; i < 3; i++) begin
            ha[i] = $urandom;
            hb[i] = $urandom;
        end
        @(negedge clk);
        a0     = ha[0];
        b0     = hb[0];
        start0 = 1'b1;
        k      = 0;
        for (int t = 1; t <= 80 && k < 3; t++) begin
            @(negedge clk);
            if (done0) begin
                check_val($sformatf("held_time_%0d", k), 64'(t), 64'((L0 + 1) * (k + 1)));
                check_val($sformatf("held_res_%0d", k), res0, ref_mul32(ha[k], hb[k]));
                k++;
                if (k < 3) begin
                    a0 = ha[k];
                    b0 = hb[k];
                end else begin
                    start0 = 1'b0;
                end
            end
        end
        start0 = 1'b0;
        check_val("held_count", 64'(k), 64'd3);
        @(negedge clk);
        check_val("held_stop_busy", 64'(busy0), 64'd0);

        // Reset during the fifth MULT cycle
        launch0(32'h0F0F_0F0F, 32'h7777_7777);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", 64'(busy0), 64'd0);
        check_val("midrst_res",  res0, 64'd0);
        seen = 0;
        for (int j = 0; j < 25; j++) begin
            if (done0) seen++;
            @(negedge clk);
        end
        check_val("midrst_no_done", 64'(seen), 64'd0);
        check_val("midrst_res_held", res0, 64'd0);
        run0("after_rst", 32'h0001_2345, 32'h0006_789A);

        // Random products on the default configuration
        for (int i = 0; i < 20; i++) begin
            run0($sformatf("rand%0d", i), $urandom, $urandom);
        end

        // Digit-width sweep on the 16x16 instances
        for (int it = 0; it < 1000; it++) begin
            sa = 16'($urandom);
            sb = 16'($urandom);
            if (it == 0) begin
                sa = 16'hFFFF;
                sb = 16'hFFFF;
            end else if (it == 1) begin
                sa = 16'h0;
            end else if (it == 2) begin
                sb = 16'h0;
            end
            @(negedge clk);
            a16     = sa;
            b16     = sb;
            start16 = 1'b1;
            @(negedge clk);
            start16 = 1'b0;
            for (int i = 0; i < 3; i++) lat_s[i] = -1;
            for (int j = 0; j <= 25; j++) begin
                for (int i = 0; i < 3; i++) begin
                    if (done_s[i] && lat_s[i] < 0) lat_s[i] = j;
                end
                @(negedge clk);
            end
            for (int i = 0; i < 3; i++) begin
                check_val($sformatf("sweep_d%0d_lat_it%0d", dig[i], it), 64'(lat_s[i]), 64'(exp_lat[i]));
                check_val($sformatf("sweep_d%0d_res_it%0d", dig[i], it), 64'(res_s[i]), ref_mul16(sa, sb));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
